accum_seq_fsm: RTL and testbench

- Parametrised successor to the single-channel state-cycling accumulator.
- N_CH independent accumulator lanes share one mode FSM: CLEAR, ACCUM, LOAD, HOLD.
- Samples are accepted over a valid/ready handshake and routed by channel index; each accepted sample produces one registered, channel-tagged result.
- Sits between a sample source and downstream logic that consumes the truncated accumulator value.

---
 rtl/accum_seq_pkg.sv | 20 ++
 rtl/accum_seq_fsm_lane.sv | 53 +++++
 rtl/accum_seq_fsm.sv | 101 ++++++++++
 tb/tb_accum_seq_fsm.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_seq_pkg.sv
// Shared types for the multi-lane accumulator: the mode encoding and its wrap sequence.
package accum_seq_pkg;

    typedef enum logic [1:0] {
        MODE_CLEAR = 2'd0,
        MODE_ACCUM = 2'd1,
        MODE_LOAD  = 2'd2,
        MODE_HOLD  = 2'd3
    } mode_t;

    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_CLEAR: next_mode = MODE_ACCUM;
            MODE_ACCUM: next_mode = MODE_LOAD;
            MODE_LOAD:  next_mode = MODE_HOLD;
            default:    next_mode = MODE_CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/accum_seq_fsm_lane.sv
// One accumulator lane. ACCUM wraps modulo 2^ACC_W unless ACCUM_SAT_EN is defined,
// in which case it saturates at all-ones.
module accum_lane
    import accum_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ACC_W  = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  mode_t             mode_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [ACC_W-1:0]  acc_c
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] acc_add;

`ifdef ACCUM_SAT_EN
    // Carry out of the widened sum means the lane would wrap; clamp instead.
    logic [ACC_W:0] sum_w;
    assign sum_w   = {1'b0, acc_q} + (ACC_W+1)'(data_i);
    assign acc_add = sum_w[ACC_W] ? '1 : sum_w[ACC_W-1:0];
`else
    assign acc_add = acc_q + ACC_W'(data_i);
`endif

    always_comb begin
        acc_d = acc_q;
        if (en_i) begin
            case (mode_i)
                MODE_CLEAR: acc_d = '0;
                MODE_ACCUM: acc_d = acc_add;
                MODE_LOAD:  acc_d = ACC_W'(data_i);
                default:    acc_d = acc_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Post-update value, so the top can register the result in the same cycle.
    assign acc_c = acc_d;

endmodule

// File: rtl/accum_seq_fsm.sv
// N_CH-lane accumulator sharing one CLEAR/ACCUM/LOAD/HOLD mode FSM, with a valid/ready
// sample input and a registered, channel-tagged result. Optional feature macro: ACCUM_SAT_EN.
module accum_seq_fsm
    import accum_seq_pkg::*;
#(
    parameter  int unsigned DATA_W = 16,
    parameter  int unsigned ACC_W  = 26,
    parameter  int unsigned N_CH   = 4,
    localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              next,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_ch,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        mode_o
);

    if (ACC_W < DATA_W) begin : g_acc_w_chk
        $error("accum_seq_fsm: ACC_W must be >= DATA_W");
    end
    if (N_CH < 1) begin : g_n_ch_chk
        $error("accum_seq_fsm: N_CH must be >= 1");
    end

    mode_t             mode_q, mode_d;
    logic              out_valid_q, out_valid_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic              xfer;
    logic [N_CH-1:0]   lane_hit;
    logic [DATA_W-1:0] sel_data;
    logic [ACC_W-1:0]  lane_acc [N_CH];

    assign in_ready = (mode_q != MODE_HOLD);
    assign xfer     = in_valid && in_ready;

    for (genvar g = 0; g < int'(N_CH); g++) begin : g_lane
        accum_lane #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .en_i   (lane_hit[g]),
            .mode_i (mode_q),
            .data_i (in_data),
            .acc_c  (lane_acc[g])
        );
    end

    // Channel decode; an out-of-range index hits no lane and so yields no result.
    always_comb begin
        mode_d      = mode_q;
        out_valid_d = 1'b0;
        out_ch_d    = out_ch_q;
        out_data_d  = out_data_q;
        lane_hit    = '0;
        sel_data    = '0;
        if (next) begin
            mode_d = next_mode(mode_q);
        end
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (in_ch == CH_W'(i)) begin
                lane_hit[i] = xfer;
                sel_data    = lane_acc[i][DATA_W-1:0];
            end
        end
        if (|lane_hit) begin
            out_valid_d = 1'b1;
            out_ch_d    = in_ch;
            out_data_d  = sel_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q      <= MODE_CLEAR;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
        end else begin
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_data  = out_data_q;
    assign mode_o    = mode_q;

endmodule

// File: tb/tb_accum_seq_fsm.sv
// Self-checking bench for accum_seq_fsm (DATA_W=16, ACC_W=17, N_CH=5): directed table,
// multi-cycle corner sequences and randomized traffic against an arithmetic reference model.
module tb_accum_seq_fsm;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ACC_W  = 17;
    localparam int unsigned N_CH   = 5;
    localparam int unsigned CH_W   = 3;
    localparam longint      ACC_MOD = 64'd1 << ACC_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              next;
    logic              in_valid;
    logic              in_ready;
    logic [CH_W-1:0]   in_ch;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [CH_W-1:0]   out_ch;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        mode_o;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int     m_mode;
    longint acc_m [N_CH];
    bit     m_valid;
    int     m_ch;
    longint m_data;

    typedef struct {
        bit nx;
        bit v;
        int ch;
        int d;
        bit ev;
        int ech;
        int ed;
        int em;
    } vec_t;

    vec_t tbl [$];

    accum_seq_fsm #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .N_CH   (N_CH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .next      (next),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_data  (out_data),
        .mode_o    (mode_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(bit nx, bit v, int ch, int d, bit ev, int ech, int ed, int em);
        vec_t r;
        r.nx = nx; r.v = v; r.ch = ch; r.d = d;
        r.ev = ev; r.ech = ech; r.ed = ed; r.em = em;
        return r;
    endfunction

    function automatic void model_reset();
        m_mode  = 0;
        m_valid = 1'b0;
        m_ch    = 0;
        m_data  = 0;
        for (int i = 0; i < int'(N_CH); i++) acc_m[i] = 0;
    endfunction

    // Apply one cycle of the mode rules; the transfer sees the pre-advance mode.
    function automatic void model_step(bit nx, bit v, int c, int d);
        m_valid = 1'b0;
        if (v && m_mode != 3 && c < int'(N_CH)) begin
            if (m_mode == 0) begin
                acc_m[c] = 0;
            end else if (m_mode == 1) begin
                acc_m[c] = acc_m[c] + longint'(d);
`ifdef ACCUM_SAT_EN
                if (acc_m[c] > ACC_MOD - 1) acc_m[c] = ACC_MOD - 1;
`else
                acc_m[c] = acc_m[c] % ACC_MOD;
`endif
            end else begin
                acc_m[c] = longint'(d);
            end
            m_valid = 1'b1;
            m_ch    = c;
            m_data  = acc_m[c] % 65536;
        end
        if (nx) m_mode = (m_mode + 1) % 4;
    endfunction

    task automatic cycle(input bit nx, input bit v, input int c, input int d);
        next     = nx;
        in_valid = v;
        in_ch    = CH_W'(c);
        in_data  = DATA_W'(d);
        #1;
        chk("in_ready", 64'(in_ready), 64'(m_mode != 3));
        model_step(nx, v, c, d);
        @(posedge clk);
        #1;
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("out_ch", 64'(out_ch), 64'(m_ch));
        chk("out_data", 64'(out_data), 64'(m_data));
        chk("mode_o", 64'(mode_o), 64'(m_mode));
    endtask

    task automatic do_reset();
        next = 1'b0; in_valid = 1'b0; in_ch = '0; in_data = '0;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_ch", 64'(out_ch), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_mode", 64'(mode_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_valid", 64'(out_valid), 64'd0);
        chk("post_rst_mode", 64'(mode_o), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        next = 1'b0; in_valid = 1'b0; in_ch = '0; in_data = '0;

        // Mode sequencing, accumulate, LOAD/HOLD, simultaneous next + transfer
        tbl.push_back(mk(1,0,0,0, 0,0,0, 1));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 1));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 1));
        tbl.push_back(mk(1,0,0,0, 0,0,0, 2));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 2));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 2));
        tbl.push_back(mk(1,0,0,0, 0,0,0, 3));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 3));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 3));
        tbl.push_back(mk(1,0,0,0, 0,0,0, 0));
        tbl.push_back(mk(1,0,0,0, 0,0,0, 1));
        tbl.push_back(mk(1,0,0,0, 0,0,0, 2));
        tbl.push_back(mk(1,0,0,0, 0,0,0, 3));
        tbl.push_back(mk(1,0,0,0, 0,0,0, 0));
        tbl.push_back(mk(1,0,0,0, 0,0,0, 1));
        tbl.push_back(mk(0,1,1,'h0005, 1,1,'h0005, 1));
        tbl.push_back(mk(0,1,1,'h0007, 1,1,'h000C, 1));
        tbl.push_back(mk(0,1,1,'hFFFF, 1,1,'h000B, 1));
        tbl.push_back(mk(1,0,0,0, 0,0,0, 2));
        tbl.push_back(mk(1,0,0,0, 0,0,0, 3));
        tbl.push_back(mk(1,0,0,0, 0,0,0, 0));
        tbl.push_back(mk(0,1,0,'hABCD, 1,0,'h0000, 0));
        tbl.push_back(mk(1,0,0,0, 0,0,0, 1));
        tbl.push_back(mk(1,0,0,0, 0,0,0, 2));
        tbl.push_back(mk(0,1,2,'h1234, 1,2,'h1234, 2));
        tbl.push_back(mk(1,0,0,0, 0,0,0, 3));
        tbl.push_back(mk(0,1,2,'h5555, 0,0,0, 3));
        tbl.push_back(mk(1,0,0,0, 0,0,0, 0));
        tbl.push_back(mk(1,0,0,0, 0,0,0, 1));
        tbl.push_back(mk(0,1,2,'h0000, 1,2,'h1234, 1));
        tbl.push_back(mk(0,1,0,'h0010, 1,0,'h0010, 1));
        tbl.push_back(mk(1,1,0,'h0003, 1,0,'h0013, 2));

        do_reset();
        foreach (tbl[k]) begin
            cycle(tbl[k].nx, tbl[k].v, tbl[k].ch, tbl[k].d);
            chk($sformatf("tbl%0d_valid", k), 64'(out_valid), 64'(tbl[k].ev));
            chk($sformatf("tbl%0d_mode", k), 64'(mode_o), 64'(tbl[k].em));
            if (tbl[k].ev) begin
                chk($sformatf("tbl%0d_ch", k), 64'(out_ch), 64'(tbl[k].ech));
                chk($sformatf("tbl%0d_data", k), 64'(out_data), 64'(tbl[k].ed));
            end
        end

        // Overflow of a 17-bit lane
        do_reset();
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 'hFFFF);
        cycle(0, 1, 0, 'hFFFF);
        cycle(0, 1, 0, 'hFFFF);
`ifdef ACCUM_SAT_EN
        chk("ovf_final", 64'(out_data), 64'h0000_FFFF);
        cycle(0, 1, 0, 'h0001);
        chk("ovf_sat_stick", 64'(out_data), 64'h0000_FFFF);
`else
        chk("ovf_final", 64'(out_data), 64'h0000_FFFD);
        cycle(0, 1, 0, 'h0001);
        chk("ovf_wrap_next", 64'(out_data), 64'h0000_FFFE);
`endif

        // Asynchronous reset mid-stream
        do_reset();
        cycle(1, 0, 0, 0);
        cycle(0, 1, 3, 'h0100);
        cycle(0, 1, 3, 'h0005);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_mode", 64'(mode_o), 64'd0);
        model_reset();
        in_valid = 1'b0;
        next = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("release_valid", 64'(out_valid), 64'd0);
        cycle(1, 0, 0, 0);
        cycle(0, 1, 3, 'h0000);
        chk("rst_lane3_cleared", 64'(out_data), 64'd0);
        cycle(0, 1, int'(N_CH), 'hFFFF);
        chk("oob_no_valid", 64'(out_valid), 64'd0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 3) == 0,
                  $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) == 0) ? 'hFFFF : int'($urandom_range(0, 65535)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
